// File: rtl/sd_card_check_state_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_card_check_state_pkg
// Brief    : Shared SD sequencer types: FSM states, CMD13/R1 constants, fields.
// Revision : 1.0 - initial release
// ============================================================================
package sd_card_check_state_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_BUSY   = 3'd1,
        S_SEND_CMD    = 3'd2,
        S_GET_RESP    = 3'd3,
        S_CHECK       = 3'd4,
        S_RETRY_DELAY = 3'd5,
        S_COMPLITE    = 3'd6,
        S_FAIL        = 3'd7
    } state_t;

    localparam logic [5:0] CMD_SEND_STATUS = 6'd13;
    localparam logic [3:0] CARD_STATE_TRAN = 4'd4;

    // Positions within the 48-bit response frame
    localparam int R1_INDEX_MSB  = 45;
    localparam int R1_INDEX_LSB  = 40;
    localparam int R1_STATUS_MSB = 39;
    localparam int R1_STATUS_LSB = 8;

    // Positions within the 32-bit card status word
    localparam int ST_ERR_MSB    = 31;
    localparam int ST_ERR_LSB    = 19;
    localparam int ST_STATE_MSB  = 12;
    localparam int ST_STATE_LSB  = 9;
    localparam int ST_READY_BIT  = 8;

    typedef struct packed {
        logic [5:0] index;
        logic [3:0] current_state;
        logic       ready_for_data;
        logic       error;
    } r1_fields_t;

    function automatic logic r1_is_tran_ready(input r1_fields_t f);
        return (f.current_state == CARD_STATE_TRAN) && f.ready_for_data;
    endfunction

    // Counter width able to hold 0..max, never narrower than one bit
    function automatic int cnt_width(input int max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_card_check_state_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_card_check_state_if
// Brief    : Controller handshake and command-unit bus of the status checker.
// Revision : 1.0 - initial release
// ============================================================================
interface sd_card_check_state_if;

    logic        CheckState_En;
    logic        CheckState_Complite;
    logic        CheckState_Fail;
    logic        Busy_Bit;
    logic [15:0] RCA_Addr;
    logic [47:0] Responce_R1_R3;
    logic [5:0]  CMD_ID;
    logic [7:0]  Arg1;
    logic [7:0]  Arg2;
    logic [7:0]  Arg3;
    logic [7:0]  Arg4;
    logic        Send_CMD_En;
    logic        Get_CMD_En;
    logic        Send_CMD_Complite;
    logic        Get_CMD_Complite;

    // master: the sequencer itself; slave: controller plus send/receive units
    modport master (
        input  CheckState_En, Busy_Bit, RCA_Addr, Responce_R1_R3,
               Send_CMD_Complite, Get_CMD_Complite,
        output CheckState_Complite, CheckState_Fail, CMD_ID,
               Arg1, Arg2, Arg3, Arg4, Send_CMD_En, Get_CMD_En
    );

    modport slave (
        output CheckState_En, Busy_Bit, RCA_Addr, Responce_R1_R3,
               Send_CMD_Complite, Get_CMD_Complite,
        input  CheckState_Complite, CheckState_Fail, CMD_ID,
               Arg1, Arg2, Arg3, Arg4, Send_CMD_En, Get_CMD_En
    );

endinterface
`default_nettype wire

// File: rtl/sd_card_check_state_r1_decode.sv
`default_nettype none
// ============================================================================
// Module   : sd_card_check_state_r1_decode
// Brief    : Extracts index, card state, READY_FOR_DATA and error summary from R1.
// Revision : 1.0 - initial release
// ============================================================================
module sd_card_check_state_r1_decode
    import sd_card_check_state_pkg::*;
(
    input  logic [47:0] resp,
    output r1_fields_t  fields
);

    logic [31:0] w_status;
    logic        w_unused_bits;

    assign w_status              = resp[R1_STATUS_MSB:R1_STATUS_LSB];
    assign fields.index          = resp[R1_INDEX_MSB:R1_INDEX_LSB];
    assign fields.current_state  = w_status[ST_STATE_MSB:ST_STATE_LSB];
    assign fields.ready_for_data = w_status[ST_READY_BIT];
    assign fields.error          = |w_status[ST_ERR_MSB:ST_ERR_LSB];

    // Start/transmission bits, CRC and non-error status bits are not inspected
    assign w_unused_bits = ^{resp[47:46], resp[7:0], w_status[18:13], w_status[7:0]};

endmodule
`default_nettype wire

// File: rtl/sd_card_check_state.sv
`default_nettype none
// ============================================================================
// Module   : sd_card_check_state
// Brief    : Waits for DAT0 busy release, issues CMD13 and checks for tran+ready.
// Revision : 1.0 - initial release
// ============================================================================
module sd_card_check_state
    import sd_card_check_state_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 100000,
    parameter int RETRY_MAX    = 8,
    parameter int RETRY_DELAY  = 100
) (
    input  wire logic             clk,
    input  wire logic             rst,
    sd_card_check_state_if.master bus
);

    localparam int c_busy_w  = cnt_width(BUSY_TIMEOUT);
    localparam int c_retry_w = cnt_width(RETRY_MAX);
    localparam int c_delay_w = cnt_width(RETRY_DELAY);

    localparam logic [c_busy_w-1:0]  c_busy_last  = c_busy_w'(BUSY_TIMEOUT - 1);
    localparam logic [c_retry_w-1:0] c_retry_last = c_retry_w'(RETRY_MAX - 1);
    localparam logic [c_delay_w-1:0] c_delay_last = c_delay_w'(RETRY_DELAY - 1);

    state_t               r_state;
    state_t               w_next;
    logic [c_busy_w-1:0]  r_busy_cnt;
    logic [c_retry_w-1:0] r_retry_cnt;
    logic [c_delay_w-1:0] r_delay_cnt;
    logic [47:0]          r_resp;
    r1_fields_t           w_fields;
    logic                 w_retry_inc;
    logic                 w_capture;
    logic                 w_send_en;
    logic                 w_get_en;
    logic                 w_complite;
    logic                 w_fail;

    sd_card_check_state_r1_decode u_r1_decode (
        .resp   (r_resp),
        .fields (w_fields)
    );

    assign bus.CMD_ID = CMD_SEND_STATUS;
    assign bus.Arg1   = bus.RCA_Addr[15:8];
    assign bus.Arg2   = bus.RCA_Addr[7:0];
    assign bus.Arg3   = 8'h00;
    assign bus.Arg4   = 8'h00;

    assign bus.Send_CMD_En         = w_send_en;
    assign bus.Get_CMD_En          = w_get_en;
    assign bus.CheckState_Complite = w_complite;
    assign bus.CheckState_Fail     = w_fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy_cnt  <= '0;
            r_retry_cnt <= '0;
            r_delay_cnt <= '0;
            r_resp      <= '0;
        end else begin
            r_state <= w_next;

            // Both wait counters restart on every entry into their state
            if (r_state == S_WAIT_BUSY && w_next == S_WAIT_BUSY) begin
                r_busy_cnt <= r_busy_cnt + 1'b1;
            end else begin
                r_busy_cnt <= '0;
            end

            if (r_state == S_RETRY_DELAY && w_next == S_RETRY_DELAY) begin
                r_delay_cnt <= r_delay_cnt + 1'b1;
            end else begin
                r_delay_cnt <= '0;
            end

            if (r_state == S_IDLE) begin
                r_retry_cnt <= '0;
            end else if (w_retry_inc) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
            end

            if (w_capture) begin
                r_resp <= bus.Responce_R1_R3;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retry_inc = 1'b0;
        w_capture   = 1'b0;

        if (!bus.CheckState_En) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next = S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!bus.Busy_Bit) begin
                        w_next = S_SEND_CMD;
                    end else if (r_busy_cnt == c_busy_last) begin
                        w_next = S_FAIL;
                    end
                end
                S_SEND_CMD: begin
                    if (bus.Send_CMD_Complite) begin
                        w_next = S_GET_RESP;
                    end
                end
                S_GET_RESP: begin
                    if (bus.Get_CMD_Complite) begin
                        w_capture = 1'b1;
                        w_next    = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_fields.index != CMD_SEND_STATUS || w_fields.error) begin
                        w_next = S_FAIL;
                    end else if (r1_is_tran_ready(w_fields)) begin
                        w_next = S_COMPLITE;
                    end else if (r_retry_cnt == c_retry_last) begin
                        w_next = S_FAIL;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_next      = S_RETRY_DELAY;
                    end
                end
                S_RETRY_DELAY: begin
                    if (r_delay_cnt == c_delay_last) begin
                        w_next = S_WAIT_BUSY;
                    end
                end
                S_COMPLITE, S_FAIL: begin
                    w_next = r_state;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_send_en  = (r_state == S_SEND_CMD);
        w_get_en   = (r_state == S_GET_RESP);
        w_complite = (r_state == S_COMPLITE);
        w_fail     = (r_state == S_FAIL);
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_card_check_state.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_card_check_state
// Brief    : Directed and randomized check of the CMD13 status sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sd_card_check_state;

    localparam int BUSY_TIMEOUT = 200;
    localparam int RETRY_MAX    = 3;
    localparam int RETRY_DELAY  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sd_card_check_state_if bus ();

    sd_card_check_state #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .RETRY_MAX    (RETRY_MAX),
        .RETRY_DELAY  (RETRY_DELAY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phases of a status check, counted down in cycles
    // ------------------------------------------------------------------
    typedef enum int {M_OFF, M_BUSYWAIT, M_CMD, M_RESP, M_EVAL, M_PAUSE, M_READY, M_FAILED} mphase_t;
    mphase_t     m_ph = M_OFF;
    int          m_busy_left, m_pause_left, m_attempts_left;
    logic [47:0] m_resp;
    longint      m_status, m_idx;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_ph   = M_OFF;
            m_resp = '0;
        end else if (!bus.CheckState_En) begin
            m_ph = M_OFF;
        end else begin
            case (m_ph)
                M_OFF: begin
                    m_ph            = M_BUSYWAIT;
                    m_busy_left     = BUSY_TIMEOUT;
                    m_attempts_left = RETRY_MAX;
                end
                M_BUSYWAIT: begin
                    if (!bus.Busy_Bit) m_ph = M_CMD;
                    else begin
                        m_busy_left--;
                        if (m_busy_left == 0) m_ph = M_FAILED;
                    end
                end
                M_CMD:  if (bus.Send_CMD_Complite) m_ph = M_RESP;
                M_RESP: if (bus.Get_CMD_Complite) begin
                    m_resp = bus.Responce_R1_R3;
                    m_ph   = M_EVAL;
                end
                M_EVAL: begin
                    m_idx    = longint'((m_resp >> 40) & 48'h3F);
                    m_status = longint'((m_resp >> 8) & 48'hFFFF_FFFF);
                    if (m_idx != 13 || m_status >= (64'd1 << 19)) m_ph = M_FAILED;
                    else if (((m_status >> 9) & 15) == 4 && ((m_status >> 8) & 1) == 1) m_ph = M_READY;
                    else begin
                        m_attempts_left--;
                        if (m_attempts_left == 0) m_ph = M_FAILED;
                        else begin
                            m_ph         = M_PAUSE;
                            m_pause_left = RETRY_DELAY;
                        end
                    end
                end
                M_PAUSE: begin
                    m_pause_left--;
                    if (m_pause_left == 0) begin
                        m_ph        = M_BUSYWAIT;
                        m_busy_left = BUSY_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("send_en",  {63'd0, bus.Send_CMD_En},         {63'd0, m_ph == M_CMD});
        chk("get_en",   {63'd0, bus.Get_CMD_En},          {63'd0, m_ph == M_RESP});
        chk("complite", {63'd0, bus.CheckState_Complite}, {63'd0, m_ph == M_READY});
        chk("fail",     {63'd0, bus.CheckState_Fail},     {63'd0, m_ph == M_FAILED});
        chk("flags_exclusive", {63'd0, bus.CheckState_Complite & bus.CheckState_Fail}, 64'd0);
        chk("cmd_id", 64'(bus.CMD_ID), 64'd13);
        chk("args", 64'({bus.Arg1, bus.Arg2, bus.Arg3, bus.Arg4}), 64'(bus.RCA_Addr) << 16);
    end

    // Rising edges of Send_CMD_En = CMD13s issued
    logic prev_send = 1'b0;
    int   rise_cyc[$];
    always @(negedge clk) begin
        if (bus.Send_CMD_En && !prev_send) rise_cyc.push_back(cyc);
        prev_send = bus.Send_CMD_En;
    end

    // ------------------------------------------------------------------
    // Command send / response receive units
    // ------------------------------------------------------------------
    logic [47:0] resp_q[$];
    bit          rand_mode   = 1'b0;
    bit          hold_get    = 1'b0;
    int          rsp_max_dly = 0;
    int          sdly = 0, gdly = 0, last_get_cyc = 0;

    function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] st);
        return {2'b00, idx, st, 8'h01};
    endfunction

    function automatic logic [47:0] rand_resp();
        logic [31:0] st;
        logic [5:0]  idx;
        int          k;
        k   = $urandom_range(0, 9);
        idx = 6'd13;
        st  = $urandom;
        if (k < 4) begin
            st[31:19] = '0;
            st[12:9]  = 4'd4;
            st[8]     = 1'b1;
        end else if (k < 8) begin
            st[31:19] = '0;
            if (st[12:9] == 4'd4) st[8] = 1'b0;
        end else if (k == 8) begin
            st = st | (32'h1 << $urandom_range(19, 31));
        end else begin
            idx = 6'($urandom);
            if (idx == 6'd13) idx = 6'd17;
        end
        return {2'($urandom), idx, st, 8'($urandom)};
    endfunction

    initial begin
        bus.Send_CMD_Complite = 1'b0;
        bus.Get_CMD_Complite  = 1'b0;
        bus.Responce_R1_R3    = '0;
        forever begin
            @(negedge clk); #1;
            bus.Send_CMD_Complite = 1'b0;
            bus.Get_CMD_Complite  = 1'b0;
            if (bus.Send_CMD_En) begin
                if (sdly == 0) begin
                    bus.Send_CMD_Complite = 1'b1;
                    sdly = $urandom_range(0, rsp_max_dly);
                end else sdly--;
            end
            if (bus.Get_CMD_En && !hold_get) begin
                if (gdly == 0) begin
                    if (resp_q.size() > 0) bus.Responce_R1_R3 = resp_q.pop_front();
                    else if (rand_mode)    bus.Responce_R1_R3 = rand_resp();
                    else                   bus.Responce_R1_R3 = mk(6'd13, 32'h0000_0900);
                    bus.Get_CMD_Complite = 1'b1;
                    last_get_cyc = cyc;
                    gdly = $urandom_range(0, rsp_max_dly);
                end else gdly--;
            end
        end
    end

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_flag(input string name, input int budget, output int at_cyc);
        bit got;
        got    = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.CheckState_Complite || bus.CheckState_Fail) begin
                got    = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        chk(name, {63'd0, got}, 64'd1);
    endtask

    task automatic finish_txn(input string name);
        bus.CheckState_En = 1'b0;
        bus.Busy_Bit      = 1'b0;
        step();
        chk(name, 64'({bus.CheckState_Complite, bus.CheckState_Fail}), 64'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int at, c0, base, abort_at, bpct;
        bit done;
        bus.CheckState_En = 1'b0;
        bus.Busy_Bit      = 1'b0;
        bus.RCA_Addr      = 16'h1234;
        repeat (3) step();
        chk("rst_outputs", 64'({bus.Send_CMD_En, bus.Get_CMD_En, bus.CheckState_Complite, bus.CheckState_Fail}), 64'd0);
        chk("rst_arg1", 64'(bus.Arg1), 64'h12);
        chk("rst_arg2", 64'(bus.Arg2), 64'h34);
        chk("rst_arg34", 64'({bus.Arg3, bus.Arg4}), 64'd0);
        rst = 1'b0;
        step();

        // Tran + ready on first attempt
        resp_q.push_back(mk(6'd13, 32'h0000_0900));
        bus.CheckState_En = 1'b1;
        wait_flag("t1_flag_seen", 100, at);
        chk("t1_complite", {63'd0, bus.CheckState_Complite}, 64'd1);
        chk("t1_latency", 64'(at - last_get_cyc), 64'd2);
        finish_txn("t1_flag_clears");

        // Busy for 50 cycles, then released
        bus.Busy_Bit      = 1'b1;
        bus.CheckState_En = 1'b1;
        repeat (50) step();
        chk("t2_no_send_while_busy", {63'd0, bus.Send_CMD_En}, 64'd0);
        bus.Busy_Bit = 1'b0;
        step();
        chk("t2_send_after_busy", {63'd0, bus.Send_CMD_En}, 64'd1);
        wait_flag("t2_flag_seen", 100, at);
        chk("t2_complite", {63'd0, bus.CheckState_Complite}, 64'd1);
        finish_txn("t2_flag_clears");

        // Busy stuck high
        base = rise_cyc.size();
        bus.Busy_Bit      = 1'b1;
        bus.CheckState_En = 1'b1;
        c0 = cyc;
        wait_flag("t3_flag_seen", 400, at);
        chk("t3_fail", {63'd0, bus.CheckState_Fail}, 64'd1);
        chk("t3_timeout_cycles", 64'(at - (c0 + 1)), 64'(BUSY_TIMEOUT));
        chk("t3_no_cmd13", 64'(rise_cyc.size() - base), 64'd0);
        finish_txn("t3_flag_clears");

        // prg first, then tran + ready
        base = rise_cyc.size();
        resp_q.push_back(mk(6'd13, 32'h0000_0E00));
        resp_q.push_back(mk(6'd13, 32'h0000_0900));
        bus.CheckState_En = 1'b1;
        wait_flag("t4_flag_seen", 200, at);
        chk("t4_complite", {63'd0, bus.CheckState_Complite}, 64'd1);
        chk("t4_cmd13_count", 64'(rise_cyc.size() - base), 64'd2);
        if (rise_cyc.size() - base == 2)
            chk("t4_cmd13_spacing", 64'(rise_cyc[base+1] - rise_cyc[base]), 64'(RETRY_DELAY + 4));
        finish_txn("t4_flag_clears");

        // Error bit and wrong index fail without retry
        base = rise_cyc.size();
        resp_q.push_back(mk(6'd13, 32'h8000_0900));
        bus.CheckState_En = 1'b1;
        wait_flag("t5a_flag_seen", 100, at);
        chk("t5a_fail", {63'd0, bus.CheckState_Fail}, 64'd1);
        chk("t5a_cmd13_count", 64'(rise_cyc.size() - base), 64'd1);
        finish_txn("t5a_flag_clears");
        base = rise_cyc.size();
        resp_q.push_back(mk(6'd17, 32'h0000_0900));
        bus.CheckState_En = 1'b1;
        wait_flag("t5b_flag_seen", 100, at);
        chk("t5b_fail", {63'd0, bus.CheckState_Fail}, 64'd1);
        chk("t5b_cmd13_count", 64'(rise_cyc.size() - base), 64'd1);
        finish_txn("t5b_flag_clears");

        // Retries exhausted
        base = rise_cyc.size();
        repeat (RETRY_MAX) resp_q.push_back(mk(6'd13, 32'h0000_0E00));
        bus.CheckState_En = 1'b1;
        wait_flag("t6_flag_seen", 300, at);
        chk("t6_fail", {63'd0, bus.CheckState_Fail}, 64'd1);
        chk("t6_cmd13_count", 64'(rise_cyc.size() - base), 64'(RETRY_MAX));
        finish_txn("t6_flag_clears");

        // Abort while waiting for the response
        hold_get = 1'b1;
        bus.CheckState_En = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            done = bus.Get_CMD_En;
        end
        chk("t7_get_en_seen", {63'd0, done}, 64'd1);
        bus.CheckState_En = 1'b0;
        step();
        chk("t7_enables_drop", 64'({bus.Send_CMD_En, bus.Get_CMD_En}), 64'd0);
        repeat (4) begin
            step();
            chk("t7_no_flag", 64'({bus.CheckState_Complite, bus.CheckState_Fail}), 64'd0);
        end
        hold_get = 1'b0;

        // Reset mid-operation
        bus.Busy_Bit      = 1'b1;
        bus.CheckState_En = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("t8_rst_abort", 64'({bus.Send_CMD_En, bus.Get_CMD_En, bus.CheckState_Complite, bus.CheckState_Fail}), 64'd0);
        rst = 1'b0;
        bus.CheckState_En = 1'b0;
        bus.Busy_Bit      = 1'b0;
        step();

        // Randomized transactions against the model
        rand_mode   = 1'b1;
        rsp_max_dly = 3;
        for (int t = 0; t < 40; t++) begin
            bus.RCA_Addr = 16'($urandom);
            case ($urandom_range(0, 7))
                0, 1, 2: bpct = 0;
                3, 4:    bpct = 30;
                5, 6:    bpct = 70;
                default: bpct = 100;
            endcase
            abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 60)) : -1;
            bus.CheckState_En = 1'b1;
            done = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                bus.Busy_Bit = ($urandom_range(0, 99) < bpct);
                step();
                if (bus.CheckState_Complite || bus.CheckState_Fail ||
                    m_ph == M_READY || m_ph == M_FAILED || c == abort_at) begin
                    done = 1'b1;
                    break;
                end
            end
            chk("rand_txn_ends", {63'd0, done}, 64'd1);
            bus.CheckState_En = 1'b0;
            bus.Busy_Bit      = 1'b0;
            repeat ($urandom_range(1, 4)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
